beam_sum_accumulator: RTL

//  Downstream of the delay beamformer. Consumes the selected-sample stream
//  (value + data_good strobe) and sums exactly NUM_TAPS selected samples per frame.

---
 rtl/beam_sum_accumulator_pkg.sv | 16 +
 rtl/beam_sum_accumulator_rise_detect.sv | 22 ++
 rtl/beam_sum_accumulator.sv | 115 +++++++++++
 3 files changed

// File: rtl/beam_sum_accumulator_pkg.sv
// Shared definitions for the beam summing slice: default sample width,
// index width of the tap ROM, and the accumulator FSM state type.
package beam_pkg;

  localparam int unsigned BEAM_DATA_W = 32;
  localparam int unsigned BEAM_IDX_W  = 10;
  // One extra bit so a full 1024-tap frame is countable.
  localparam int unsigned BEAM_CNT_W  = BEAM_IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } beam_state_t;

endpackage

// File: rtl/beam_sum_accumulator_rise_detect.sv
// rise_detect: one-cycle pulse on a 0->1 transition of sig.
//   clk      in  clock, posedge
//   reset_n  in  asynchronous active-low reset (registered copy clears to 0)
//   sig      in  level to watch
//   rise     out sig & ~sig_registered
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sig_q <= 1'b0;
    else          sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/beam_sum_accumulator.sv
// beam_sum_accumulator: sums exactly NUM_TAPS selected samples per frame and
// presents the frame sum with a valid/ready handshake.
//   clk        in   clock, posedge
//   reset_n    in   asynchronous active-low reset
//   start      in   frame enable; a rising edge opens a frame, low aborts it
//   in_value   in   signed selected sample (DATA_W)
//   in_valid   in   strobe: in_value is a selected sample
//   sum_value  out  signed frame sum (ACC_W)
//   sum_valid  out  sum_value holds a completed frame sum
//   sum_ready  in   consumer accepts when sum_valid & sum_ready
//   busy       out  frame in progress
//   tap_count  out  samples accumulated in the current frame
//   overrun    out  sticky: strobe seen while no frame open
module beam_sum_accumulator
  import beam_pkg::*;
#(
  parameter int unsigned DATA_W   = BEAM_DATA_W,
  parameter int unsigned NUM_TAPS = 64,
  parameter int unsigned ACC_W    = 42
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     in_value,
  input  logic                  in_valid,
  output logic [ACC_W-1:0]      sum_value,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic                  busy,
  output logic [BEAM_CNT_W-1:0] tap_count,
  output logic                  overrun
);

  if (ACC_W < DATA_W + $clog2(NUM_TAPS)) begin : g_acc_w_check
    $error("beam_sum_accumulator: ACC_W too narrow for DATA_W and NUM_TAPS");
  end
  if (NUM_TAPS < 1 || NUM_TAPS > (1 << BEAM_IDX_W)) begin : g_taps_check
    $error("beam_sum_accumulator: NUM_TAPS out of range");
  end

  localparam logic [BEAM_CNT_W-1:0] LAST_TAP = BEAM_CNT_W'(NUM_TAPS);

  beam_state_t      state_q, state_d;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sample_ext;
  logic             start_rise;
  logic             frame_full;

  rise_detect u_start_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .sig     (start),
    .rise    (start_rise)
  );

  assign sample_ext = {{(ACC_W-DATA_W){in_value[DATA_W-1]}}, in_value};
  assign frame_full = (tap_count == LAST_TAP);
  assign busy       = (state_q == ST_ACCUM);
  assign sum_valid  = (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_rise) state_d = ST_ACCUM;
      // Abort outranks both a pending strobe and frame completion.
      ST_ACCUM: if (!start)         state_d = ST_IDLE;
                else if (frame_full) state_d = ST_HOLD;
      ST_HOLD:  if (sum_ready)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // The last strobe lands in acc/tap_count first; the sum is published on
  // the following edge, giving one cycle between final strobe and sum_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      sum_value <= '0;
      tap_count <= '0;
      overrun   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            acc       <= '0;
            tap_count <= '0;
            overrun   <= 1'b0;
          end else if (in_valid) begin
            overrun   <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (start) begin
            if (frame_full) begin
              sum_value <= acc;
            end else if (in_valid) begin
              acc       <= acc + sample_ext;
              tap_count <= tap_count + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (in_valid) overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
